multi_condition_gen: RTL
========================

Name: multi_condition_gen

Overview:
- Multi-channel successor to the single-channel period × freq_adj condition register.
- Computes a terminal-count condition `period[ch]*freq_adj[ch] - OFFSET` for CHANNELS independent clock generators.
- Uses one time-shared, registered multiplier scanned round-robin.
- Each channel's condition only changes when its recomputed value differs. Downstream clock dividers get a one-cycle update strobe per change.

Parameters:
- CHANNELS, 4: number of independent channels (≥1).
- PERIOD_W, 15: width of each period input.
- ADJ_W, 15: width of each freq_adj input.
- COND_W, 32: width of each condition output.
- OFFSET, 0: unsigned constant subtracted from each product.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- period  in  CHANNELS*PERIOD_W  packed periods; ch0 in LSBs.
- freq_adj  in  CHANNELS*ADJ_W  packed frequency adjust; ch0 in LSBs.
- ch_en  in  CHANNELS  per-channel write enable.
- condition  out  CHANNELS*COND_W  packed registered conditions.
- cond_valid  out  CHANNELS  channel evaluated at least once since reset.
- cond_upd  out  CHANNELS  one-cycle pulse when channel condition is written with a new value.
- sweep_done  out  1  one-cycle pulse when the scan pointer wraps.

Behaviour:
- Reset (reset_n low, asynchronous):
  - every condition lane = 1; cond_valid = 0; cond_upd = 0; sweep_done = 0.
  - scan pointer = 0; pipeline valid bits cleared.
  - Reset mid-scan discards in-flight results.
- Scan pointer ptr:
  - increments every clk from 0 to CHANNELS-1, then wraps to 0.
  - sweep_done pulses in the cycle ptr wraps, registered.
- Stage 1 (registered):
  - capture `p1_ch=ptr`.
  - `p1_prod = period[ptr]*freq_adj[ptr]`, full width PERIOD_W+ADJ_W, unsigned.
  - set p1_vld.
- Stage 2 (registered):
  - `res = p1_prod - OFFSET`, then fit to COND_W per the Optional Feature rules.
  - Without the macro, a result wider than COND_W keeps the low COND_W bits (modulo).
  - p2_ch, p2_vld follow stage 1.
- Stage 3 (commit, registered):
  - Condition: p2_vld and ch_en[p2_ch] sampled at the commit cycle.
  - If res != condition[p2_ch]: write condition[p2_ch] = res and pulse cond_upd[p2_ch] for one cycle.
  - Whenever the condition holds: set cond_valid[p2_ch] = 1, even if no value change.
  - If ch_en[p2_ch] = 0: no write, no pulse, cond_valid unchanged.
- Latency:
  - each channel is sampled once per CHANNELS cycles.
  - from sample cycle to condition update: 3 cycles.
  - worst case from an input change to output: CHANNELS+3 cycles.
- Stable inputs produce no cond_upd pulses after the first sweep.
- Inputs change mid-pipeline: the value sampled in stage 1 is committed; the new value is picked up on the next visit.
- At most one cond_upd bit high per cycle.
- CHANNELS=1: the pointer stays at 0, sweep_done is high every cycle, and the channel is re-evaluated each cycle.
- No combinational path from inputs to outputs.
- The multiplier is inferred; the DSP attribute is allowed.

Optional Feature:
- Macro: MULTI_COND_SAT_EN.
- Defined:
  - if p1_prod < OFFSET, res = 0.
  - if p1_prod - OFFSET exceeds 2^COND_W-1, res = all ones.
- Undefined:
  - subtraction is modulo 2^(PERIOD_W+ADJ_W); truncated to COND_W LSBs.
  - With default widths, underflow then yields the low 32 bits of a 30-bit wrap (zero-extended).

Test Plan (CHANNELS=4, OFFSET=2, defaults otherwise):
1. Hold reset_n=0 for 5 cycles with nonzero inputs -> every condition lane = 1, cond_valid=0, cond_upd=0, sweep_done=0. Assert reset_n=0 mid-scan -> same values immediately.
2. Release reset; ch0 period=100, freq_adj=50, ch_en=4'hF -> condition[0]=4998 within 7 cycles, single cond_upd[0] pulse, cond_valid[0]=1.
3. Static inputs for 100 cycles after first sweep -> zero cond_upd pulses; sweep_done pulses exactly every 4 cycles.
4. ch2 period=7; change freq_adj 10→20 -> condition[2] goes 68→138 within 7 cycles with one cond_upd[2] pulse; other lanes unchanged.
5. ch_en[1]=0; change ch1 inputs to 3×3 -> condition[1] held, no pulse for 20 cycles. Set ch_en[1]=1 -> condition[1]=7 within 7 cycles, one pulse.
6. ch3 period=1, freq_adj=1 -> with MULTI_COND_SAT_EN, condition[3]=0. Without it, condition[3]=32'h3FFFFFFF.

Source files
------------

// File: rtl/multi_condition_gen.sv
// multi_condition_gen: per-channel terminal-count conditions computed as
// period[ch]*freq_adj[ch] - OFFSET by one shared multiplier that is scanned
// round-robin over CHANNELS clock generators.
//
// Ports:
//   clk        - system clock, all state on the rising edge
//   reset_n    - asynchronous active-low reset
//   period     - CHANNELS x PERIOD_W packed periods, ch0 in the LSBs
//   freq_adj   - CHANNELS x ADJ_W packed frequency adjusts, ch0 in the LSBs
//   ch_en      - per-channel commit enable
//   condition  - CHANNELS x COND_W packed registered conditions
//   cond_valid - channel committed at least once since reset
//   cond_upd   - one-cycle strobe when a channel condition changes value
//   sweep_done - one-cycle strobe when the scan pointer wraps
//
// Optional build macro MULTI_COND_SAT_EN: clamp the result to [0, 2^COND_W-1]
// instead of the default modulo subtraction and truncation.
module multi_condition_gen #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned PERIOD_W = 15,
    parameter int unsigned ADJ_W    = 15,
    parameter int unsigned COND_W   = 32,
    parameter int unsigned OFFSET   = 0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [CHANNELS*PERIOD_W-1:0] period,
    input  logic [CHANNELS*ADJ_W-1:0]    freq_adj,
    input  logic [CHANNELS-1:0]          ch_en,
    output logic [CHANNELS*COND_W-1:0]   condition,
    output logic [CHANNELS-1:0]          cond_valid,
    output logic [CHANNELS-1:0]          cond_upd,
    output logic                         sweep_done
);

    localparam int unsigned PW = PERIOD_W + ADJ_W;
    localparam int unsigned IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned MW = (PW > COND_W) ? PW : COND_W;
    localparam int unsigned WW = ((MW > 32) ? MW : 32) + 1;
    localparam logic [IW-1:0] LAST = IW'(CHANNELS - 1);

    // Unpacked views of the packed channel inputs
    logic [PERIOD_W-1:0] per_a [CHANNELS];
    logic [ADJ_W-1:0]    adj_a [CHANNELS];

    always_comb begin
        for (int i = 0; i < int'(CHANNELS); i++) begin
            per_a[i] = period[i*PERIOD_W +: PERIOD_W];
            adj_a[i] = freq_adj[i*ADJ_W +: ADJ_W];
        end
    end

    // Scan pointer and wrap strobe
    logic [IW-1:0] ptr_q, ptr_d;
    logic          sweep_q, sweep_d;

    always_comb begin
        ptr_d   = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
        sweep_d = (ptr_q == LAST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q   <= '0;
            sweep_q <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            sweep_q <= sweep_d;
        end
    end

    // Stage 1: shared multiplier on the channel under the pointer
    logic [PW-1:0] op_a, op_b;
    logic [PW-1:0] p1_prod_q, p1_prod_d;
    logic [IW-1:0] p1_ch_q;
    logic          p1_vld_q;

    always_comb begin
        op_a      = PW'(per_a[ptr_q]);
        op_b      = PW'(adj_a[ptr_q]);
        p1_prod_d = op_a * op_b;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p1_prod_q <= '0;
            p1_ch_q   <= '0;
            p1_vld_q  <= 1'b0;
        end else begin
            p1_prod_q <= p1_prod_d;
            p1_ch_q   <= ptr_q;
            p1_vld_q  <= 1'b1;
        end
    end

    // Stage 2: offset subtraction and fit to COND_W
    logic [COND_W-1:0] res_d;

`ifdef MULTI_COND_SAT_EN
    logic [WW-1:0] prod_w, off_w, max_w, diff_w;

    always_comb begin
        prod_w = WW'(p1_prod_q);
        off_w  = WW'(OFFSET);
        max_w  = WW'({COND_W{1'b1}});
        diff_w = prod_w - off_w;
        if (prod_w < off_w) begin
            res_d = '0;
        end else if (diff_w > max_w) begin
            res_d = '1;
        end else begin
            res_d = COND_W'(diff_w);
        end
    end
`else
    localparam logic [PW-1:0] OFF_PW = PW'(OFFSET);
    logic [PW-1:0] diff_pw;

    // Wraps modulo 2^PW, then zero-extends or truncates to COND_W
    always_comb begin
        diff_pw = p1_prod_q - OFF_PW;
        res_d   = COND_W'(diff_pw);
    end
`endif

    logic [COND_W-1:0] p2_res_q;
    logic [IW-1:0]     p2_ch_q;
    logic              p2_vld_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p2_res_q <= '0;
            p2_ch_q  <= '0;
            p2_vld_q <= 1'b0;
        end else begin
            p2_res_q <= res_d;
            p2_ch_q  <= p1_ch_q;
            p2_vld_q <= p1_vld_q;
        end
    end

    // Stage 3: commit into the channel's condition register
    logic [COND_W-1:0]   cond_q [CHANNELS];
    logic [CHANNELS-1:0] valid_q;
    logic [CHANNELS-1:0] upd_q;
    logic                commit;
    logic                changed;

    always_comb begin
        commit  = p2_vld_q && ch_en[p2_ch_q];
        changed = (p2_res_q != cond_q[p2_ch_q]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                cond_q[i] <= COND_W'(1);
            end
            valid_q <= '0;
            upd_q   <= '0;
        end else begin
            upd_q <= '0;
            if (commit) begin
                valid_q[p2_ch_q] <= 1'b1;
                if (changed) begin
                    cond_q[p2_ch_q] <= p2_res_q;
                    upd_q[p2_ch_q]  <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        condition = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            condition[i*COND_W +: COND_W] = cond_q[i];
        end
    end

    assign cond_valid = valid_q;
    assign cond_upd   = upd_q;
    assign sweep_done = sweep_q;

endmodule
